// File: rtl/moore_run_detector_fsm.sv
// Moore run detector: z asserts once w has been high on RUN_LEN
// consecutive rising edges; state is a saturating run counter.
module moore_run_detector_fsm #(
  parameter int RUN_LEN = 2,
  parameter int SW      = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          w,
  output logic          z,
  output logic [SW-1:0] state
);

  typedef logic [SW-1:0] state_t;

  localparam state_t S_RUN = state_t'(RUN_LEN);
  localparam state_t S_ONE = state_t'(1);

  if (RUN_LEN < 1 || RUN_LEN > 15) begin : g_bad_len
    $error("RUN_LEN out of range 1..15");
  end
  if (SW != $clog2(RUN_LEN + 1)) begin : g_bad_sw
    $error("SW must equal clog2(RUN_LEN+1)");
  end

  state_t state_q;
  state_t state_d;

  // Codes above RUN_LEN fall back to 0 so the FSM cannot lock up.
  always_comb begin
    state_d = '0;
    if (w) begin
      if (state_q < S_RUN) begin
        state_d = state_q + S_ONE;
      end else if (state_q == S_RUN) begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign z     = (state_q == S_RUN);
  assign state = state_q;

endmodule

// File: tb/tb_moore_run_detector_fsm.sv
// Scoreboard bench for moore_run_detector_fsm: directed vectors on the
// default instance and on a RUN_LEN=3 instance.
module tb_moore_run_detector_fsm;

  logic       clk;
  logic       reset_n;
  logic       w;
  logic       w3;
  logic       z;
  logic       z3;
  logic [1:0] state;
  logic [1:0] state3;

  moore_run_detector_fsm #(.RUN_LEN(2), .SW(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .w       (w),
    .z       (z),
    .state   (state)
  );

  moore_run_detector_fsm #(.RUN_LEN(3), .SW(2)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .w       (w3),
    .z       (z3),
    .state   (state3)
  );

  typedef struct {
    string      name;
    bit         sel3;
    logic [1:0] st;
    logic       zz;
  } exp_t;

  exp_t queue_q[$];
  event sample_ev;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Monitor: pops one expectation per sample event and compares.
  initial begin
    forever begin
      @(sample_ev);
      checks++;
      if (queue_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: sample with empty queue");
      end else begin
        exp_t e;
        logic [1:0] a_st;
        logic       a_z;
        e    = queue_q.pop_front();
        a_st = e.sel3 ? state3 : state;
        a_z  = e.sel3 ? z3 : z;
        if (a_st !== e.st || a_z !== e.zz) begin
          errors++;
          $display("FAIL %s: got state=%b z=%b, required state=%b z=%b",
                   e.name, a_st, a_z, e.st, e.zz);
        end
      end
    end
  end

  task automatic chk(input string n, input bit s3,
                     input logic [1:0] st, input logic zz);
    exp_t e;
    e.name = n;
    e.sel3 = s3;
    e.st   = st;
    e.zz   = zz;
    queue_q.push_back(e);
    ->sample_ev;
    #1;
  endtask

  task automatic step(input string n, input logic wv,
                      input logic [1:0] st, input logic zz);
    w = wv;
    @(posedge clk);
    #1;
    chk(n, 1'b0, st, zz);
  endtask

  task automatic step3(input string n, input logic wv,
                       input logic [1:0] st, input logic zz);
    w3 = wv;
    @(posedge clk);
    #1;
    chk(n, 1'b1, st, zz);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    w       = 1'b0;
    w3      = 1'b0;
    #1;
    chk("rst_t0", 1'b0, 2'b00, 1'b0);
    step("rst_hold1", 1'b0, 2'b00, 1'b0);
    step("rst_hold2", 1'b0, 2'b00, 1'b0);
    step("rst_hold3", 1'b1, 2'b00, 1'b0);
    reset_n = 1'b1;
    step("rst_rel_w1", 1'b1, 2'b01, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_pulse", 1'b0, 2'b00, 1'b0);
    reset_n = 1'b1;

    // Detection
    step("det_w0", 1'b0, 2'b00, 1'b0);
    step("det_w1a", 1'b1, 2'b01, 1'b0);
    step("det_w1b", 1'b1, 2'b10, 1'b1);
    step("det_w1c", 1'b1, 2'b10, 1'b1);

    // Broken run
    reset_n = 1'b0;
    #1;
    chk("brk_rst", 1'b0, 2'b00, 1'b0);
    reset_n = 1'b1;
    step("brk_w1a", 1'b1, 2'b01, 1'b0);
    step("brk_w0", 1'b0, 2'b00, 1'b0);
    step("brk_w1b", 1'b1, 2'b01, 1'b0);
    step("brk_w1c", 1'b1, 2'b10, 1'b1);

    // Output holds while w toggles between edges, then drops
    w = 1'b0;
    chk("tog_a", 1'b0, 2'b10, 1'b1);
    w = 1'b1;
    chk("tog_b", 1'b0, 2'b10, 1'b1);
    w = 1'b0;
    chk("tog_c", 1'b0, 2'b10, 1'b1);
    step("drop_w0", 1'b0, 2'b00, 1'b0);

    // Async reset mid-run
    step("mid_w1a", 1'b1, 2'b01, 1'b0);
    step("mid_w1b", 1'b1, 2'b10, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst", 1'b0, 2'b00, 1'b0);
    reset_n = 1'b1;
    step("mid_rel_w1", 1'b1, 2'b01, 1'b0);

    // Illegal-state recovery
    force dut.state_q = 2'b11;
    #1;
    chk("ill_forced", 1'b0, 2'b11, 1'b0);
    release dut.state_q;
    step("ill_w0", 1'b0, 2'b00, 1'b0);
    force dut.state_q = 2'b11;
    #1;
    release dut.state_q;
    step("ill_w1", 1'b1, 2'b00, 1'b0);
    w = 1'b0;

    // RUN_LEN = 3 sweep
    step3("r3_w1a", 1'b1, 2'b01, 1'b0);
    step3("r3_w1b", 1'b1, 2'b10, 1'b0);
    step3("r3_w0", 1'b0, 2'b00, 1'b0);
    step3("r3_w1c", 1'b1, 2'b01, 1'b0);
    step3("r3_w1d", 1'b1, 2'b10, 1'b0);
    step3("r3_w1e", 1'b1, 2'b11, 1'b1);
    step3("r3_w1f", 1'b1, 2'b11, 1'b1);
    step3("r3_drop", 1'b0, 2'b00, 1'b0);

    #5;
    checks++;
    if (queue_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left, required 0",
               queue_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
